// File: rtl/cache_pkg.sv
// Shared constants for the set-associative cache: parameter defaults and
// widths derived from them, used by the way-select datapath and its cells.
package cache_pkg;

  localparam int DEF_WAYS            = 4;
  localparam int DEF_TAG_BITS        = 18;
  localparam int DEF_LINE_SIZE_BYTES = 64;
  localparam int DEF_OFFSET_BITS     = 6;
  localparam int DEF_DATA_WIDTH      = 32;

  localparam int LINE_BITS    = 8 * DEF_LINE_SIZE_BYTES;
  localparam int WAY_IDX_BITS = $clog2(DEF_WAYS);
  localparam int LINE_WIDTH   = LINE_BITS;

endpackage

// File: rtl/sa_cache_way_select_way_hit_cell.sv
// One way's hit detector: stored tag equals request tag, qualified by the
// way's valid bit. Purely combinational.
module way_hit_cell
  import cache_pkg::*;
#(
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic [TAG_BITS-1:0] tag_stored,
  input  logic [TAG_BITS-1:0] tag_req,
  input  logic                way_valid,
  output logic                hit
);

  assign hit = way_valid & (tag_stored == tag_req);

endmodule

// File: rtl/sa_cache_way_select.sv
// Hit detection and way selection for the set-associative cache. Compares
// every way's tag, muxes the hitting line with a one-hot AND-OR, extracts
// the addressed word and registers the result once for the controller.
module sa_cache_way_select
  import cache_pkg::*;
#(
  parameter int WAYS            = DEF_WAYS,
  parameter int TAG_BITS        = DEF_TAG_BITS,
  parameter int LINE_SIZE_BYTES = DEF_LINE_SIZE_BYTES,
  parameter int OFFSET_BITS     = DEF_OFFSET_BITS,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  input  logic [TAG_BITS-1:0]                  i_tag,
  input  logic [OFFSET_BITS-1:0]               i_offset,
  input  logic [WAYS*TAG_BITS-1:0]             i_way_tags,
  input  logic [WAYS-1:0]                      i_way_valid,
  input  logic [WAYS*8*LINE_SIZE_BYTES-1:0]    i_way_lines,
  output logic                                 o_valid,
  output logic [WAYS-1:0]                      o_hit_vec,
  output logic                                 o_hit,
  output logic                                 o_miss,
  output logic [$clog2(WAYS)-1:0]              o_hit_way,
  output logic                                 o_multi_hit,
  output logic [8*LINE_SIZE_BYTES-1:0]         line_data,
  output logic [DATA_WIDTH-1:0]                o_data
);

  localparam int LINE_W = 8 * LINE_SIZE_BYTES;
  localparam int IDX_W  = $clog2(WAYS);

  // Lowest-index set bit; zero when nothing is set.
  function automatic logic [IDX_W-1:0] first_set(input logic [WAYS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vec[w]) idx = IDX_W'(w);
    end
    return idx;
  endfunction

  // True when at least two bits of the vector are set.
  function automatic logic more_than_one(input logic [WAYS-1:0] vec);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (vec[w]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return multi;
  endfunction

  // Word starting at a byte offset; bytes past the end of the line are
  // zero-filled rather than wrapping to the start of the line.
  function automatic logic [DATA_WIDTH-1:0] extract_word(
    input logic [LINE_W-1:0]      line,
    input logic [OFFSET_BITS-1:0] off
  );
    logic [LINE_W+DATA_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, line} >> {off, 3'b000};
    return ext[DATA_WIDTH-1:0];
  endfunction

  logic [WAYS-1:0]       hit_p0;
  logic [LINE_W-1:0]     line_p0;
  logic [DATA_WIDTH-1:0] word_p0;
  logic [IDX_W-1:0]      way_p0;
  logic                  multi_p0;
  logic                  any_p0;

  logic                  vld_p1;
  logic [WAYS-1:0]       hit_vec_p1;
  logic                  hit_p1;
  logic                  miss_p1;
  logic [IDX_W-1:0]      way_p1;
  logic                  multi_p1;
  logic [LINE_W-1:0]     line_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // ---- stage p0: per-way compare, line mux, encode, word extract ----
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    way_hit_cell #(
      .TAG_BITS (TAG_BITS)
    ) u_cell (
      .tag_stored (i_way_tags[w*TAG_BITS +: TAG_BITS]),
      .tag_req    (i_tag),
      .way_valid  (i_way_valid[w]),
      .hit        (hit_p0[w])
    );
  end

  // One-hot AND-OR line mux; multiple hits OR their lines together.
  always_comb begin
    line_p0 = '0;
    for (int w = 0; w < WAYS; w++) begin
      line_p0 = line_p0 | (i_way_lines[w*LINE_W +: LINE_W] & {LINE_W{hit_p0[w]}});
    end
  end

  assign any_p0   = |hit_p0;
  assign way_p0   = first_set(hit_p0);
  assign multi_p0 = more_than_one(hit_p0);
  assign word_p0  = extract_word(line_p0, i_offset);

  // ---- stage p1: result registers; idle cycles hold data, drop valid/miss ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      hit_vec_p1 <= '0;
      hit_p1     <= 1'b0;
      miss_p1    <= 1'b0;
      way_p1     <= '0;
      multi_p1   <= 1'b0;
      line_p1    <= '0;
      data_p1    <= '0;
    end else if (i_valid) begin
      vld_p1     <= 1'b1;
      hit_vec_p1 <= hit_p0;
      hit_p1     <= any_p0;
      miss_p1    <= ~any_p0;
      way_p1     <= way_p0;
      multi_p1   <= multi_p0;
      line_p1    <= line_p0;
      data_p1    <= word_p0;
    end else begin
      vld_p1  <= 1'b0;
      miss_p1 <= 1'b0;
    end
  end

  assign o_valid     = vld_p1;
  assign o_hit_vec   = hit_vec_p1;
  assign o_hit       = hit_p1;
  assign o_miss      = miss_p1;
  assign o_hit_way   = way_p1;
  assign o_multi_hit = multi_p1;
  assign line_data   = line_p1;
  assign o_data      = data_p1;

endmodule

// File: tb/tb_sa_cache_way_select.sv
// Scoreboard bench for sa_cache_way_select: a byte-level reference model
// queues the expected registered result for every cycle driven, and a
// monitor compares the DUT outputs against the queue on each falling edge.
module tb_sa_cache_way_select;

  localparam int WAYS = 4;
  localparam int TB_TAG = 18;
  localparam int LBYTES = 64;
  localparam int LW = 512;
  localparam int DW = 32;

  typedef struct packed {
    logic          valid;
    logic [3:0]    hv;
    logic          hit;
    logic          miss;
    logic [1:0]    way;
    logic          multi;
    logic [LW-1:0] line;
    logic [DW-1:0] data;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic                   i_valid;
  logic [TB_TAG-1:0]      i_tag;
  logic [5:0]             i_offset;
  logic [WAYS*TB_TAG-1:0] wtags;
  logic [WAYS-1:0]        wvalid;
  logic [WAYS*LW-1:0]     wlines;
  logic                   o_valid;
  logic [WAYS-1:0]        o_hit_vec;
  logic                   o_hit;
  logic                   o_miss;
  logic [1:0]             o_hit_way;
  logic                   o_multi_hit;
  logic [LW-1:0]          line_data;
  logic [DW-1:0]          o_data;

  exp_t q[$];
  exp_t prev;
  int   n_chk;
  int   n_fail;

  sa_cache_way_select dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_tag       (i_tag),
    .i_offset    (i_offset),
    .i_way_tags  (wtags),
    .i_way_valid (wvalid),
    .i_way_lines (wlines),
    .o_valid     (o_valid),
    .o_hit_vec   (o_hit_vec),
    .o_hit       (o_hit),
    .o_miss      (o_miss),
    .o_hit_way   (o_hit_way),
    .o_multi_hit (o_multi_hit),
    .line_data   (line_data),
    .o_data      (o_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tagname);
    chk({tagname, "_valid"}, LW'(o_valid), '0);
    chk({tagname, "_hitvec"}, LW'(o_hit_vec), '0);
    chk({tagname, "_hit"}, LW'(o_hit), '0);
    chk({tagname, "_miss"}, LW'(o_miss), '0);
    chk({tagname, "_way"}, LW'(o_hit_way), '0);
    chk({tagname, "_multi"}, LW'(o_multi_hit), '0);
    chk({tagname, "_line"}, line_data, '0);
    chk({tagname, "_data"}, LW'(o_data), '0);
  endtask

  // Reference: what the registered outputs must show after this request.
  function automatic exp_t model(input logic v, input logic [TB_TAG-1:0] tag, input int off);
    exp_t e;
    int   cnt;
    int   idx;
    if (!v) begin
      e = prev;
      e.valid = 1'b0;
      e.miss  = 1'b0;
      return e;
    end
    e = '0;
    cnt = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (wvalid[w] && wtags[w*TB_TAG +: TB_TAG] == tag) begin
        e.hv[w] = 1'b1;
        e.line  = e.line | wlines[w*LW +: LW];
        if (cnt == 0) e.way = 2'(w);
        cnt++;
      end
    end
    for (int b = 0; b < DW / 8; b++) begin
      idx = off + b;
      if (idx < LBYTES) e.data[8*b +: 8] = e.line[8*idx +: 8];
    end
    e.valid = 1'b1;
    e.hit   = (cnt > 0);
    e.miss  = (cnt == 0);
    e.multi = (cnt > 1);
    return e;
  endfunction

  // Drives one cycle from a falling edge, queues its expected result after
  // the rising edge, and returns on the following falling edge.
  task automatic lookup(input logic v, input logic [TB_TAG-1:0] tag, input int off);
    exp_t e;
    i_valid  = v;
    i_tag    = tag;
    i_offset = 6'(off);
    @(posedge clk);
    e = model(v, tag, off);
    prev = e;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_line(input int w);
    for (int k = 0; k < LW / 32; k++) wlines[w*LW + 32*k +: 32] = $urandom;
  endtask

  // Monitor: every queued cycle is compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", LW'(o_valid), LW'(e.valid));
        chk("hit_vec", LW'(o_hit_vec), LW'(e.hv));
        chk("hit", LW'(o_hit), LW'(e.hit));
        chk("miss", LW'(o_miss), LW'(e.miss));
        chk("hit_way", LW'(o_hit_way), LW'(e.way));
        chk("multi_hit", LW'(o_multi_hit), LW'(e.multi));
        chk("line_data", line_data, e.line);
        chk("data", LW'(o_data), LW'(e.data));
      end
    end
  end

  initial begin
    logic [LW-1:0] ff_line;
    logic [LW-1:0] way2_line;
    n_chk = 0;
    n_fail = 0;
    prev = '0;
    clk = 1'b0;
    rst = 1'b1;
    i_valid = 1'b0;
    i_tag = '0;
    i_offset = '0;
    wtags = '0;
    wvalid = '0;
    wlines = '0;
    #1 chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single hit in way 2, word at bytes 4..7.
    wtags = {18'h333, 18'h2A5, 18'h222, 18'h111};
    wvalid = 4'b1111;
    for (int w = 0; w < WAYS; w++) rand_line(w);
    wlines[2*LW + 32 +: 32] = 32'hDEADBEEF;
    way2_line = wlines[2*LW +: LW];
    lookup(1'b1, 18'h2A5, 4);
    #1;
    chk("dir_data", LW'(o_data), LW'(32'hDEADBEEF));
    chk("dir_hitvec", LW'(o_hit_vec), LW'(4'b0100));
    chk("dir_way", LW'(o_hit_way), LW'(2'd2));
    chk("dir_line", line_data, way2_line);

    // Tag equal in way 1 but not valid.
    wtags = {18'h333, 18'h111, 18'h2A5, 18'h111};
    wvalid = 4'b1101;
    lookup(1'b1, 18'h2A5, 8);
    #1;
    chk("inv_miss", LW'(o_miss), LW'(1'b1));
    chk("inv_line", line_data, '0);

    // Multi-hit: ways 0 and 3 share the tag.
    wtags = {18'h100, 18'h055, 18'h066, 18'h100};
    wvalid = 4'b1001;
    wlines[0 +: LW] = {LBYTES{8'h0F}};
    wlines[3*LW +: LW] = {LBYTES{8'hF0}};
    ff_line = {LBYTES{8'hFF}};
    lookup(1'b1, 18'h100, 0);
    #1;
    chk("multi_flag", LW'(o_multi_hit), LW'(1'b1));
    chk("multi_way", LW'(o_hit_way), '0);
    chk("multi_line", line_data, ff_line);

    // Offset boundary: partial word past the end, then the last full word.
    wvalid = 4'b0001;
    rand_line(0);
    lookup(1'b1, 18'h100, 62);
    #1 chk("off62_hi", LW'(o_data[31:16]), '0);
    lookup(1'b1, 18'h100, 60);
    #1 chk("off60", LW'(o_data), LW'(wlines[60*8 +: 32]));

    // Back-to-back A, B then idle cycles holding B.
    wvalid = 4'b1111;
    wtags = {18'h4, 18'h3, 18'h2, 18'h1};
    lookup(1'b1, 18'h1, 12);
    lookup(1'b1, 18'h3, 20);
    lookup(1'b0, 18'h3, 20);
    #1 chk("hold_way", LW'(o_hit_way), LW'(2'd2));
    lookup(1'b0, 18'h0, 0);

    // Asynchronous reset mid-cycle with nonzero outputs.
    lookup(1'b1, 18'h4, 0);
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    i_valid = 1'b1;
    @(posedge clk);
    #1 chk_zero("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    prev = '0;
    lookup(1'b0, 18'h4, 0);

    // Randomized traffic with a small tag pool to force hits and multi-hits.
    for (int n = 0; n < 300; n++) begin
      for (int w = 0; w < WAYS; w++) begin
        wtags[w*TB_TAG +: TB_TAG] = 18'($urandom_range(0, 3));
        rand_line(w);
      end
      wvalid = 4'($urandom);
      lookup(($urandom_range(0, 3) != 0), 18'($urandom_range(0, 3)), $urandom_range(0, 63));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", LW'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
